// File: rtl/h80cpu_mem_ws.sv
// h80cpu_mem_ws: parametrised on-chip RAM slave for the h80 CPU bus with programmable wait states
//
// Ports:
//   clk      - clock
//   reset    - synchronous, active-high; returns the FSM to IDLE, storage is kept
//   ce_n     - chip enable, active-low; master holds addr/cmd/data_ stable while low
//   addr     - byte address, word index = addr[BUS_ADDR_WIDTH-1:1]
//   cmd      - bus command, cmd[0]=1 marks a read
//   data_    - bidirectional data, driven with the read register while ce_n=0 and cmd[0]=1
//   wait_n   - low while selected and not yet responding
//   err      - high in the response cycle of an out-of-range access
//   wp_fault - sticky write-protect violation flag
//
// Optional feature macro: H80MEM_WRITE_PROTECT_EN
//   defined   - words [0, ROM_WORDS) reject writes and set wp_fault until reset
//   undefined - all words writable, wp_fault tied low
//
// Command encodings mirror h80bus.svh: 2 write, 3 read (dword), 4 write_w, 5 read_w,
// 6 write_b, 7 read_b; codes 0 and 1 are undefined.
module h80cpu_mem_ws #(
  parameter int    BUS_ADDR_WIDTH = 16,
  parameter int    BUS_CMD_WIDTH  = 3,
  parameter int    BUS_DATA_WIDTH = 16,
  parameter int    DEPTH_WORDS    = 32768,
  parameter int    RD_WAIT        = 0,
  parameter int    WR_WAIT        = 0,
  parameter string INIT_FILE      = "",
  parameter int    ROM_WORDS      = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ce_n,
  input  logic [BUS_ADDR_WIDTH-1:0] addr,
  input  logic [BUS_CMD_WIDTH-1:0]  cmd,
  inout  wire  [BUS_DATA_WIDTH-1:0] data_,
  output logic                      wait_n,
  output logic                      err,
  output logic                      wp_fault
);
  localparam int DW = BUS_DATA_WIDTH;
  localparam int IW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [BUS_CMD_WIDTH-1:0] CMD_WRITE   = BUS_CMD_WIDTH'(2);
  localparam logic [BUS_CMD_WIDTH-1:0] CMD_READ    = BUS_CMD_WIDTH'(3);
  localparam logic [BUS_CMD_WIDTH-1:0] CMD_WRITE_W = BUS_CMD_WIDTH'(4);
  localparam logic [BUS_CMD_WIDTH-1:0] CMD_READ_W  = BUS_CMD_WIDTH'(5);
  localparam logic [BUS_CMD_WIDTH-1:0] CMD_WRITE_B = BUS_CMD_WIDTH'(6);
  localparam logic [BUS_CMD_WIDTH-1:0] CMD_READ_B  = BUS_CMD_WIDTH'(7);

  if (BUS_DATA_WIDTH != 16 && BUS_DATA_WIDTH != 32) begin : g_bad_width
    $error("h80cpu_mem_ws: BUS_DATA_WIDTH must be 16 or 32");
  end
  if (RD_WAIT < 0 || RD_WAIT > 15 || WR_WAIT < 0 || WR_WAIT > 15) begin : g_bad_wait
    $error("h80cpu_mem_ws: RD_WAIT/WR_WAIT must lie in 0..15");
  end
  if (ROM_WORDS < 0 || ROM_WORDS > DEPTH_WORDS) begin : g_bad_rom
    $error("h80cpu_mem_ws: ROM_WORDS must lie in 0..DEPTH_WORDS");
  end

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                    state_q, state_d;
  logic [BUS_CMD_WIDTH-1:0]  cmd_q, cmd_d;
  logic [BUS_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]                cnt_q, cnt_d;
  logic [DW-1:0]             rd_data_q, rd_data_d;
  logic                      wp_fault_q, wp_fault_d;

  logic [15:0]   mem [DEPTH_WORDS];
  logic [31:0]   lo_w, hi_w, wd;
  logic [IW-1:0] lo_idx, hi_idx;
  logic [15:0]   lo, hi, lo_new;
  logic [DW-1:0] rd_val;
  logic          start, oor, is_wr, wr_dw, wp_hit, perform, we_lo, we_hi;

  assign data_ = (!ce_n && cmd[0]) ? rd_data_q : 'z;

  // Datapath: word selection, range check, read mux and write merge
  always_comb begin
    lo_w    = 32'(addr_q[BUS_ADDR_WIDTH-1:1]);
    // high word of a dword wraps to 0 at the top of storage
    hi_w    = (lo_w + 32'd1 == 32'(DEPTH_WORDS)) ? 32'd0 : lo_w + 32'd1;
    lo_idx  = IW'(lo_w);
    hi_idx  = IW'(hi_w);
    lo      = mem[lo_idx];
    hi      = mem[hi_idx];
    oor     = lo_w >= 32'(DEPTH_WORDS);
    wd      = 32'(data_);
    start   = state_q == IDLE && !ce_n;
    is_wr   = cmd_q == CMD_WRITE || cmd_q == CMD_WRITE_W || cmd_q == CMD_WRITE_B;
    wr_dw   = cmd_q == CMD_WRITE && DW == 32;
`ifdef H80MEM_WRITE_PROTECT_EN
    wp_hit  = is_wr && !oor && (lo_w < 32'(ROM_WORDS) || (wr_dw && hi_w < 32'(ROM_WORDS)));
`else
    wp_hit  = 1'b0;
`endif
    perform = state_q == BUSY && !ce_n && cnt_q == 4'd0;
    // reset on the perform edge must not leave a partial write behind
    we_lo   = perform && !reset && is_wr && !oor && !wp_hit;
    we_hi   = we_lo && wr_dw;
    lo_new  = cmd_q == CMD_WRITE_B ? (addr_q[0] ? {wd[7:0], lo[7:0]} : {lo[15:8], wd[7:0]}) : wd[15:0];
    // on a 16-bit bus the dword cast keeps only the low word, matching read_w
    rd_val  = oor ? '0 :
              cmd_q == CMD_READ   ? DW'({hi, lo}) :
              cmd_q == CMD_READ_W ? DW'(lo) :
              cmd_q == CMD_READ_B ? DW'(addr_q[0] ? lo[15:8] : lo[7:0]) : '0;
  end

  always_comb begin
    cmd_d      = start ? cmd : cmd_q;
    addr_d     = start ? addr : addr_q;
    cnt_d      = start ? (cmd[0] ? 4'(RD_WAIT) : 4'(WR_WAIT)) :
                 (state_q == BUSY && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    rd_data_d  = (perform && !is_wr) ? rd_val : rd_data_q;
    wp_fault_d = wp_fault_q | (perform && wp_hit);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      addr_q     <= '0;
      cnt_q      <= 4'd0;
      rd_data_q  <= '0;
      wp_fault_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      wp_fault_q <= wp_fault_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we_lo) mem[lo_idx] <= lo_new;
    if (we_hi) mem[hi_idx] <= wd[31:16];
  end

  always_comb begin
    state_d = state_q == IDLE ? (ce_n ? IDLE : BUSY) :
              state_q == BUSY ? (ce_n ? IDLE : cnt_q == 4'd0 ? RESP : BUSY) : IDLE;
  end

  always_comb begin
    wait_n   = ce_n || state_q == RESP;
    err      = state_q == RESP && oor;
    wp_fault = wp_fault_q;
  end
endmodule

// File: tb/tb_h80cpu_mem_ws.sv
// tb_h80cpu_mem_ws: directed bench for h80cpu_mem_ws checked against a word-array model
module tb_h80cpu_mem_ws;
  localparam logic [2:0] C_WR = 3'd2, C_RD = 3'd3, C_WRW = 3'd4, C_RDW = 3'd5, C_WRB = 3'd6, C_RDB = 3'd7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1, ce_a_n = 1'b1, ce_b_n = 1'b1, drv_a = 1'b0, drv_b = 1'b0;
  logic [15:0] addr = '0;
  logic [2:0]  cmd = '0;
  logic [31:0] wdata = '0;
  wire  [31:0] data_a;
  wire  [15:0] data_b;
  logic        wn_a, err_a, wp_a, wn_b, err_b, wp_b;

  assign data_a = drv_a ? wdata : 'z;
  assign data_b = drv_b ? wdata[15:0] : 'z;

  h80cpu_mem_ws #(.BUS_DATA_WIDTH(32), .DEPTH_WORDS(1024)) u_a (
    .clk(clk), .reset(reset), .ce_n(ce_a_n), .addr(addr), .cmd(cmd),
    .data_(data_a), .wait_n(wn_a), .err(err_a), .wp_fault(wp_a));

  h80cpu_mem_ws #(.BUS_DATA_WIDTH(16), .DEPTH_WORDS(64), .RD_WAIT(3), .WR_WAIT(1), .ROM_WORDS(16)) u_b (
    .clk(clk), .reset(reset), .ce_n(ce_b_n), .addr(addr), .cmd(cmd),
    .data_(data_b), .wait_n(wn_b), .err(err_b), .wp_fault(wp_b));

  int          checks = 0, errors = 0;
  logic [15:0] ma [1024];
  logic [15:0] mb [64];
  logic        exp_wp_b = 1'b0;
  logic        last_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mrd(input int sel, input int i);
    return sel != 0 ? mb[i % 64] : ma[i % 1024];
  endfunction

  task automatic mwr(input int sel, input int i, input logic [15:0] v);
    if (sel != 0) mb[i] = v;
    else ma[i] = v;
  endtask

  // Bank-level model: A is a 32-bit bus over 1024 words, B a 16-bit bus over 64 words
  task automatic model(input int sel, input logic [2:0] c, input logic [15:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic e);
    int depth, wi, hi;
    logic [15:0] lo_v, hi_v;
    logic w32, prot;
    depth = sel != 0 ? 64 : 1024;
    w32 = sel == 0;
    wi = int'(a) / 2;
    hi = (wi + 1) % depth;
    e = wi >= depth;
    lo_v = mrd(sel, wi);
    hi_v = mrd(sel, hi);
    prot = 1'b0;
`ifdef H80MEM_WRITE_PROTECT_EN
    prot = sel == 1 && wi < 16;
`endif
    rd = 0;
    if (!e) begin
      if (c == C_RDW) rd = {16'h0, lo_v};
      if (c == C_RDB) rd = a[0] ? {24'h0, lo_v[15:8]} : {24'h0, lo_v[7:0]};
      if (c == C_RD) rd = w32 ? {hi_v, lo_v} : {16'h0, lo_v};
      if (c == C_WRW || c == C_WRB || c == C_WR) begin
        if (prot) exp_wp_b = 1'b1;
        else if (c == C_WRW) mwr(sel, wi, wd[15:0]);
        else if (c == C_WRB) mwr(sel, wi, a[0] ? {wd[7:0], lo_v[7:0]} : {lo_v[15:8], wd[7:0]});
        else begin
          mwr(sel, wi, wd[15:0]);
          if (w32) mwr(sel, hi, wd[31:16]);
        end
      end
    end
  endtask

  task automatic access(input int sel, input logic [2:0] c, input logic [15:0] a, input logic [31:0] wd,
                        output logic [31:0] rd);
    int n = 0;
    logic wn = 1'b0, e, ee;
    logic [31:0] er;
    @(posedge clk);
    #1;
    addr = a; cmd = c; wdata = wd;
    if (sel == 0) begin ce_a_n = 1'b0; drv_a = !c[0]; end
    else begin ce_b_n = 1'b0; drv_b = !c[0]; end
    while (!wn && n < 40) begin
      @(negedge clk);
      wn = sel != 0 ? wn_b : wn_a;
      if (!wn) n++;
    end
    rd = sel != 0 ? {16'h0, data_b} : data_a;
    e = sel != 0 ? err_b : err_a;
    last_err = e;
    @(posedge clk);
    #1;
    ce_a_n = 1'b1; ce_b_n = 1'b1; drv_a = 1'b0; drv_b = 1'b0;
    model(sel, c, a, wd, er, ee);
    chk("latency", n, 2 + (sel == 0 ? 0 : (c[0] ? 3 : 1)));
    if (c[0]) chk("rdata", rd, er);
    chk("err", {31'h0, e}, {31'h0, ee});
    chk("wp_fault_b", {31'h0, wp_b}, {31'h0, exp_wp_b});
    chk("wp_fault_a", {31'h0, wp_a}, 0);
  endtask

  // Deselected slaves must never stall the bus or flag an error
  always @(negedge clk) if (!reset) begin
    if (ce_a_n) begin chk("idle_wait_n_a", {31'h0, wn_a}, 1); chk("idle_err_a", {31'h0, err_a}, 0); end
    if (ce_b_n) begin chk("idle_wait_n_b", {31'h0, wn_b}, 1); chk("idle_err_b", {31'h0, err_b}, 0); end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_wait_n_a", {31'h0, wn_a}, 1);
    chk("rst_wp_a", {31'h0, wp_a}, 0);
    chk("rst_wait_n_b", {31'h0, wn_b}, 1);
    chk("rst_wp_b", {31'h0, wp_b}, 0);
    // word write/read, zero wait states
    access(0, C_WRW, 16'h0010, 32'h1234, r);
    access(0, C_RDW, 16'h0010, 0, r);
    chk("t1_lit", r, 32'h0000_1234);
    // byte lanes
    access(0, C_WRW, 16'h0020, 32'h5566, r);
    access(0, C_WRB, 16'h0021, 32'h0000_00AB, r);
    access(0, C_RDW, 16'h0020, 0, r);
    chk("t3_word", r, 32'h0000_AB66);
    access(0, C_RDB, 16'h0021, 0, r);
    chk("t3_byte_hi", r, 32'h0000_00AB);
    access(0, C_RDB, 16'h0020, 0, r);
    chk("t3_byte_lo", r, 32'h0000_0066);
    access(0, C_WRB, 16'h0020, 32'hFFFF_FFCD, r);
    access(0, C_RDW, 16'h0020, 0, r);
    chk("t3_byte_lo_wr", r, 32'h0000_ABCD);
    // dword wrap at the top of storage and out-of-range access
    access(0, C_WR, 16'h07FE, 32'hDEAD_BEEF, r);
    chk("t4_wrap_err", {31'h0, last_err}, 0);
    access(0, C_RDW, 16'h07FE, 0, r);
    chk("t4_lo", r, 32'h0000_BEEF);
    access(0, C_RDW, 16'h0000, 0, r);
    chk("t4_hi", r, 32'h0000_DEAD);
    access(0, C_RD, 16'h07FE, 0, r);
    chk("t4_dword", r, 32'hDEAD_BEEF);
    access(0, C_RDW, 16'h0800, 0, r);
    chk("t4_oor_data", r, 0);
    chk("t4_oor_err", {31'h0, last_err}, 1);
    access(0, C_WRW, 16'h0800, 32'h4242, r);
    access(0, C_RDW, 16'h0000, 0, r);
    access(0, C_WR, 16'h0006, 32'h1122_3344, r);
    access(0, C_RDW, 16'h0008, 0, r);
    chk("odd_dword_hi", r, 32'h0000_1122);
    // undefined codes complete without side effects
    access(0, 3'd1, 16'h0010, 0, r);
    chk("undef_rd", r, 0);
    access(0, 3'd0, 16'h0010, 32'h9999, r);
    access(0, C_RDW, 16'h0010, 0, r);
    chk("undef_wr_keep", r, 32'h0000_1234);
    // wait states on the 16-bit bank
    access(1, C_WRW, 16'h0040, 32'hCAFE, r);
    access(1, C_RDW, 16'h0040, 0, r);
    chk("t2_word", r, 32'h0000_CAFE);
    access(1, C_RD, 16'h0040, 0, r);
    chk("t2_dword16", r, 32'h0000_CAFE);
    access(1, C_WRB, 16'h0041, 32'h5A, r);
    access(1, C_RDW, 16'h0040, 0, r);
    chk("t2_byte", r, 32'h0000_5AFE);
    access(1, C_RDW, 16'h0080, 0, r);
    chk("b_oor_err", {31'h0, last_err}, 1);
    // aborts
    access(1, C_WRW, 16'h0050, 32'h1111, r);
    access(1, C_RDW, 16'h0050, 0, r);
    @(posedge clk);
    #1 addr = 16'h0040; cmd = C_RDW; ce_b_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 ce_b_n = 1'b1;
    @(negedge clk);
    chk("abort_wait_n", {31'h0, wn_b}, 1);
    repeat (2) @(posedge clk);
    #1 addr = 16'h0060; cmd = C_RDW; ce_b_n = 1'b0;
    @(negedge clk);
    chk("abort_rd_keep", {16'h0, data_b}, 32'h0000_1111);
    @(posedge clk);
    #1 ce_b_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 addr = 16'h0050; cmd = C_WRW; wdata = 32'h2222; drv_b = 1'b1; ce_b_n = 1'b0;
    @(posedge clk);
    #1 ce_b_n = 1'b1; drv_b = 1'b0;
    repeat (2) @(posedge clk);
    access(1, C_RDW, 16'h0050, 0, r);
    chk("abort_wr_keep", r, 32'h0000_1111);
    // reset on the edge that would perform the write
    @(posedge clk);
    #1 addr = 16'h0050; cmd = C_WRW; wdata = 32'h3333; drv_b = 1'b1; ce_b_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0; ce_b_n = 1'b1; drv_b = 1'b0; exp_wp_b = 1'b0;
    @(negedge clk);
    chk("rst_mid_wait_n", {31'h0, wn_b}, 1);
    access(1, C_RDW, 16'h0050, 0, r);
    chk("rst_mid_keep", r, 32'h0000_1111);
`ifdef H80MEM_WRITE_PROTECT_EN
    access(1, C_WRW, 16'h001E, 32'h7777, r);
    chk("t6_wp_set", {31'h0, wp_b}, 1);
    access(1, C_WRW, 16'h0020, 32'h8888, r);
    access(1, C_RDW, 16'h0020, 0, r);
    chk("t6_unprot", r, 32'h0000_8888);
    chk("t6_wp_hold", {31'h0, wp_b}, 1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0; exp_wp_b = 1'b0;
    @(negedge clk);
    chk("t6_wp_clear", {31'h0, wp_b}, 0);
`endif
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
